// File: rtl/instr_mem_if.sv
// -----------------------------------------------------------------------------
// instr_mem_if
// Fetch-side bus between an instruction fetch unit (master) and the
// instruction memory responder (slave).
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds its payload stable while valid=1 and ready=0.
//   flush discards any in-flight fetch. A response presented in a flush
//   cycle is not transferred, even if resp_ready=1.
//
// Signals:
//   req_valid  (m->s) fetch address presented
//   req_ready  (s->m) responder can accept a request this cycle
//   req_addr   (m->s) byte address of the fetch (PC)
//   flush      (m->s) branch redirect, drop in-flight fetch
//   resp_valid (s->m) resp_data / resp_err valid
//   resp_ready (m->s) fetch unit consumes the response
//   resp_data  (s->m) fetched instruction word
//   resp_err   (s->m) misaligned or out-of-range fetch
// -----------------------------------------------------------------------------
interface instr_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, flush, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, resp_ready,
        output req_ready, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/instr_mem_responder.sv
// -----------------------------------------------------------------------------
// instr_mem_responder
// Instruction memory with a fixed-latency fetch port and a program-load
// write port. One fetch is in flight at a time. The handshake cycle of a
// response can also accept the next request, so responses can run
// back-to-back.
//
// Parameters:
//   DEPTH    number of 32-bit instruction words
//   LATENCY  cycles from the request accept cycle to resp_valid (1..7)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset. Memory contents are kept.
//   bus         instr_mem_if.slave (request / response / flush)
//   load_en     program-load write strobe
//   load_addr   word index for the program load
//   load_data   instruction word to write
//   resp_count  number of completed response handshakes, wraps at 16 bits
//   o_dbg_state current FSM state (0 IDLE, 1 BUSY, 2 RESP)
// -----------------------------------------------------------------------------
module instr_mem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    instr_mem_if.slave               bus,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [31:0]              load_data,
    output logic [15:0]              resp_count,
    output logic [1:0]               o_dbg_state
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [2:0]  CNT_LD  = 3'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Program memory. It is not reset, so a loaded program survives rst.
    logic [31:0] r_mem [DEPTH] = '{default: NOP};

    state_t      r_state;
    state_t      w_state_next;
    state_t      w_accept_state;
    logic [2:0]  r_cnt;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic [15:0] r_resp_count;

    logic        w_req_ready;
    logic        w_accept;
    logic        w_handshake;
    logic [29:0] w_word;
    logic [AW-1:0] w_idx;
    logic        w_err;
    logic        w_load_ok;

    // The flush term keeps a redirected fetch from being accepted in the same
    // cycle that drops the old one.
    assign w_req_ready = !bus.flush &&
                         (r_state == S_IDLE || (r_state == S_RESP && bus.resp_ready));
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_handshake = (r_state == S_RESP) && bus.resp_ready && !bus.flush;

    assign w_word  = bus.req_addr[31:2];
    assign w_idx   = w_word[AW-1:0];
    assign w_err   = (bus.req_addr[1:0] != 2'b00) || ({2'b00, w_word} >= DEPTH_U);
    assign w_load_ok = load_en && (32'(load_addr) < DEPTH_U);

    // With single-cycle latency the accept edge goes straight to RESP.
    assign w_accept_state = (LATENCY == 1) ? S_RESP : S_BUSY;

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_state_next = w_accept_state;
                S_BUSY: if (r_cnt == 3'd1) w_state_next = S_RESP;
                S_RESP: if (bus.resp_ready) w_state_next = w_accept ? w_accept_state : S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0;
            r_resp_err   <= 1'b0;
            r_resp_count <= 16'h0;
        end else begin
            r_state      <= w_state_next;
            r_resp_valid <= (w_state_next == S_RESP);
            if (w_accept) begin
                r_cnt      <= CNT_LD;
                r_resp_err <= w_err;
                // The array is read here, before this edge's load write
                // lands, so a same-word load returns the old data.
                r_resp_data <= w_err ? NOP : r_mem[w_idx];
            end else if (r_state == S_BUSY && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_handshake) begin
                r_resp_count <= r_resp_count + 16'd1;
            end
        end
    end

    // Program-load port. A load issued during rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_load_ok) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_err   = r_resp_err;
    assign resp_count     = r_resp_count;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;
    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
    localparam int AW      = 10;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [15:0]   resp_count;
    logic [1:0]    dbg_state;

    instr_mem_if bus();

    instr_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .resp_count (resp_count),
        .o_dbg_state(dbg_state)
    );

    // scoreboard: {err, data}
    logic [32:0] exp_q[$];
    logic [32:0] mon_exp;
    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: compare every delivered response
    always @(negedge clk) begin
        if (!rst && bus.resp_valid && bus.resp_ready && !bus.flush) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL resp_unexpected: got %h expected none",
                         {bus.resp_err, bus.resp_data});
            end else begin
                mon_exp = exp_q.pop_front();
                chk("resp", {bus.resp_err, bus.resp_data}, mon_exp);
            end
        end
    end

    // driver tasks (called at posedge + 1)
    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] addr, input bit push,
                         input logic [32:0] exp, output int acc);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        acc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_timeout: got no req_ready expected accept for %h", addr);
        end else if (push) begin
            exp_q.push_back(exp);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // returns at the negedge where resp_valid is first seen
    task automatic wait_resp(input int acc, input string nm);
        int seen;
        seen = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                seen = cyc;
                break;
            end
        end
        if (seen < 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s_timeout: got no resp_valid expected one", nm);
        end else begin
            chk({nm, "_latency"}, 33'(seen - acc), 33'(LATENCY));
        end
    endtask

    task automatic finish_cnt(input logic [15:0] e, input string nm);
        @(posedge clk); #1;
        @(negedge clk);
        chk(nm, 33'(resp_count), 33'(e));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end expected end");
        $fatal(1, "timeout");
    end

    int acc;

    initial begin
        rst = 1'b1;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.flush = 1'b0; bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_resp_valid", 33'(bus.resp_valid), 33'd0);
        chk("rst_resp_data",  33'(bus.resp_data),  33'd0);
        chk("rst_resp_err",   33'(bus.resp_err),   33'd0);
        chk("rst_resp_count", 33'(resp_count),     33'd0);
        chk("rst_req_ready",  33'(bus.req_ready),  33'd1);
        chk("rst_state",      33'(dbg_state),      33'd0);
        @(posedge clk); #1;

        // basic fetch of a loaded word
        load_word(10'd1, 32'h00A0_0093);
        load_word(10'd2, 32'h0020_8133);
        fetch(32'h4, 1'b1, {1'b0, 32'h00A0_0093}, acc);
        wait_resp(acc, "basic");
        finish_cnt(16'd1, "count_basic");

        // backpressure: data stable, req_ready low until handshake
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h4;
        @(negedge clk);
        chk("bp_req_ready_idle", 33'(bus.req_ready), 33'd1);
        acc = cyc;
        exp_q.push_back({1'b0, 32'h00A0_0093});
        @(posedge clk); #1;
        bus.req_addr = 32'h8;
        wait_resp(acc, "bp_first");
        for (int i = 0; i < 3; i++) begin
            if (i != 0) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
            chk("bp_hold_data",  33'(bus.resp_data),  33'h00A0_0093);
            chk("bp_hold_valid", 33'(bus.resp_valid), 33'd1);
            chk("bp_req_ready",  33'(bus.req_ready),  33'd0);
        end
        exp_q.push_back({1'b0, 32'h0020_8133});
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_req_ready_hs", 33'(bus.req_ready), 33'd1);
        acc = cyc;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(acc, "bp_second");
        finish_cnt(16'd3, "count_bp");

        // error fetches and last valid word
        fetch(32'h6, 1'b1, {1'b1, NOP}, acc);
        wait_resp(acc, "misaligned");
        finish_cnt(16'd4, "count_mis");
        fetch(32'h1000, 1'b1, {1'b1, NOP}, acc);
        wait_resp(acc, "out_of_range");
        finish_cnt(16'd5, "count_oor");
        fetch(32'hFFC, 1'b1, {1'b0, NOP}, acc);
        wait_resp(acc, "last_word");
        finish_cnt(16'd6, "count_last");

        // flush while BUSY
        fetch(32'h8, 1'b0, 33'd0, acc);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("flush_busy_no_valid", 33'(bus.resp_valid), 33'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("flush_busy_count", 33'(resp_count), 33'd6);
        @(posedge clk); #1;
        fetch(32'h8, 1'b1, {1'b0, 32'h0020_8133}, acc);
        wait_resp(acc, "after_flush");
        finish_cnt(16'd7, "count_after_flush");

        // flush and resp_ready together in RESP
        bus.resp_ready = 1'b0;
        fetch(32'h4, 1'b0, 33'd0, acc);
        wait_resp(acc, "flush_resp");
        @(posedge clk); #1;
        bus.flush = 1'b1;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("flush_resp_valid", 33'(bus.resp_valid), 33'd0);
        chk("flush_resp_count", 33'(resp_count),     33'd7);
        @(posedge clk); #1;

        // same-cycle load and fetch of one word
        load_en = 1'b1; load_addr = 10'd3; load_data = 32'h0020_81B3;
        bus.req_valid = 1'b1; bus.req_addr = 32'hC;
        @(negedge clk);
        chk("rbw_req_ready", 33'(bus.req_ready), 33'd1);
        acc = cyc;
        exp_q.push_back({1'b0, NOP});
        @(posedge clk); #1;
        load_en = 1'b0; bus.req_valid = 1'b0;
        wait_resp(acc, "rbw_old");
        finish_cnt(16'd8, "count_rbw");
        fetch(32'hC, 1'b1, {1'b0, 32'h0020_81B3}, acc);
        wait_resp(acc, "rbw_new");
        finish_cnt(16'd9, "count_rbw_new");

        // reset while BUSY
        fetch(32'h8, 1'b0, 33'd0, acc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy_state", 33'(dbg_state),  33'd0);
        chk("rst_busy_count", 33'(resp_count), 33'd0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy_no_valid", 33'(bus.resp_valid), 33'd0);
            @(posedge clk); #1;
        end

        // reset while RESP
        bus.resp_ready = 1'b0;
        fetch(32'h4, 1'b0, 33'd0, acc);
        wait_resp(acc, "rst_resp");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        chk("rst_resp_valid_after", 33'(bus.resp_valid), 33'd0);
        chk("rst_resp_count_after", 33'(resp_count),     33'd0);
        @(posedge clk); #1;

        // loaded words survive reset
        fetch(32'h4, 1'b1, {1'b0, 32'h00A0_0093}, acc);
        wait_resp(acc, "keep_1");
        finish_cnt(16'd1, "count_keep_1");
        fetch(32'hC, 1'b1, {1'b0, 32'h0020_81B3}, acc);
        wait_resp(acc, "keep_3");
        finish_cnt(16'd2, "count_keep_3");

        repeat (5) @(posedge clk);
        chk("queue_empty", 33'(exp_q.size()), 33'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 Parameter: DEPTH, default 1024, number of 32-bit instruction words.
REQ-002 Parameter: LATENCY, default 2, legal range 1..7, cycles from request accept to response valid.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  fetch unit presents a fetch address.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address of the fetch (the PC).
REQ-008 flush  input  1  branch redirect; discard any in-flight fetch.
REQ-009 resp_valid  output  1  resp_data and resp_err are valid.
REQ-010 resp_ready  input  1  fetch unit consumes the response.
REQ-011 resp_data  output  32  fetched instruction word.
REQ-012 resp_err  output  1  misaligned or out-of-range fetch.
REQ-013 load_en  input  1  program-load write strobe.
REQ-014 load_addr  input  log2(DEPTH)  word index for the program load.
REQ-015 load_data  input  32  instruction word to write.
REQ-016 resp_count  output  16  number of completed response handshakes.

Function
REQ-017 Storage shall be DEPTH x 32 words, initialised at time zero to 0x00000013 (NOP), with contents unaffected by rst.
REQ-018 FSM states shall be IDLE, BUSY and RESP.
REQ-019 req_ready shall equal !flush && (state==IDLE || (state==RESP && resp_ready)), so one request at a time can be in flight and responses can run back-to-back.
REQ-020 Accept shall be req_valid && req_ready; on accept the block shall latch the read word, the error flag, and a latency counter loaded with LATENCY-1.
REQ-021 On accept with LATENCY==1, the next state shall be RESP; otherwise the next state shall be BUSY.
REQ-022 In BUSY the counter shall decrement each cycle and move to RESP when it equals 1, so resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-023 In RESP, resp_valid=1 and resp_data/resp_err shall hold stable until resp_ready=1.
REQ-024 On a RESP handshake, the next state shall be BUSY/RESP if a new accept occurs in the same cycle, otherwise IDLE.
REQ-025 Read word shall be mem[req_addr[31:2]], sampled at the accept cycle.
REQ-026 Error: if req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH, then resp_err=1, resp_data=0x00000013 and no array read occurs.
REQ-027 A load_en write shall take effect at the clock edge in any state.
REQ-028 If a load and an accept target the same word in the same cycle, the response shall return the old data (read-before-write).
REQ-029 load_en with load_addr>=DEPTH shall be ignored.
REQ-030 flush=1 in any state shall move the FSM to IDLE next cycle; resp_valid=0 next cycle, the pending response is discarded, no handshake occurs, and resp_count does not increment.
REQ-031 Flush and resp_ready in the same RESP cycle: flush shall take priority and the response shall not count as delivered.
REQ-032 resp_count shall increment by 1 on each resp_valid && resp_ready && !flush, and wrap from 0xFFFF to 0x0000.
REQ-033 Outputs shall be registered except req_ready, which has the combinational path defined in REQ-019.

Reset
REQ-034 When rst=1 at a clock edge: state=IDLE, counter=0, resp_valid=0, resp_data=0x00000000, resp_err=0, resp_count=0.
REQ-035 rst shall have priority over flush, load_en and accept.
REQ-036 req_ready shall be 1 in the first cycle after reset deassertion when flush=0.
REQ-037 rst asserted mid-operation (BUSY or RESP) shall drop the in-flight fetch with no response emitted.
REQ-038 Memory contents, including program-loaded words, shall survive rst.

Verification
REQ-039 LATENCY=2: load mem[1]=0x00A00093; accept addr 0x4 at cycle T -> resp_valid=1 at T+2 with data 0x00A00093, resp_err=0, resp_count=1 after the handshake.
REQ-040 resp_ready held 0 for 3 cycles in RESP -> resp_data stable; with req_valid=1 continuously, req_ready=1 only in the handshake cycle and the next response arrives LATENCY cycles later.
REQ-041 Accept addr 0x6 -> resp_err=1, data 0x00000013; accept addr 0x1000 (DEPTH=1024) -> resp_err=1.
REQ-042 Flush asserted one cycle after accept (BUSY) -> no resp_valid, resp_count unchanged; the next request at addr 0x8 returns mem[2] normally.
REQ-043 Same-cycle load mem[3]=0x002081B3 (old value 0x00000013) and accept addr 0xC -> response 0x00000013; a subsequent fetch of 0xC returns 0x002081B3.
REQ-044 rst pulsed during RESP -> resp_valid=0 and resp_count=0 next cycle; previously loaded words are still readable.
